arith_pipeline: RTL and testbench

- Four-stage registered datapath computing res = a*b + c - d*e, modulo 2^W.
- Operands are captured when load is high and the result appears a fixed number of clocks later.
- Serves as the arithmetic pipeline block of the assembly-pipeline design.
- Fully synchronous except for the clear.

---
 rtl/arith_pipeline_pkg.sv | 18 +
 rtl/arith_pipeline_if.sv | 19 +
 rtl/arith_pipeline_pipe_reg.sv | 27 ++
 rtl/arith_pipeline.sv | 102 ++++++++++
 tb/tb_arith_pipeline.sv | 116 +++++++++++
 5 files changed

// File: rtl/arith_pipeline_pkg.sv
// Shared constants and width helpers for the arith_pipeline datapath.
package arith_pipeline_pkg;

  localparam int W_DEFAULT = 3;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  function automatic int sum_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int diff_w(input int w);
    return 2 * w + 2;
  endfunction

endpackage

// File: rtl/arith_pipeline_if.sv
// Operand/result bundle for driving arith_pipeline from a producer.
interface arith_pipeline_if
  import arith_pipeline_pkg::*;
#(
  parameter int W = W_DEFAULT
) ();

  logic         load;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic [W-1:0] d;
  logic [W-1:0] e;
  logic [W-1:0] res;

  modport master (output load, a, b, c, d, e, input res);
  modport slave  (input load, a, b, c, d, e, output res);

endinterface

// File: rtl/arith_pipeline_pipe_reg.sv
// Width-parameterised pipeline register: async active-high clear, sync enable.
module arith_pipeline_pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Storage element; holds its value whenever the enable is low.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_q <= {WIDTH{1'b0}};
    end else if (i_en) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/arith_pipeline.sv
// Four-stage pipeline computing res = a*b + c - d*e modulo 2^W, latency 3 clocks from capture.
module arith_pipeline
  import arith_pipeline_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic [W-1:0] e,
  input  logic         clk,
  input  logic         load,
  input  logic         clear,
  output logic [W-1:0] res
);

  localparam int PROD_W = prod_w(W);
  localparam int SUM_W  = sum_w(W);
  localparam int DIFF_W = diff_w(W);

  localparam int S1_W = 5 * W;
  localparam int S2_W = 2 * PROD_W + W;
  localparam int S3_W = SUM_W + PROD_W;

  logic [S1_W-1:0]   w_s1_d;
  logic [S1_W-1:0]   w_s1_q;
  logic [W-1:0]      w_a1;
  logic [W-1:0]      w_b1;
  logic [W-1:0]      w_c1;
  logic [W-1:0]      w_d1;
  logic [W-1:0]      w_e1;

  logic [PROD_W-1:0] w_p1;
  logic [PROD_W-1:0] w_p2;
  logic [S2_W-1:0]   w_s2_d;
  logic [S2_W-1:0]   w_s2_q;
  logic [PROD_W-1:0] w_p1_2;
  logic [PROD_W-1:0] w_p2_2;
  logic [W-1:0]      w_c2;

  logic [SUM_W-1:0]  w_sum;
  logic [S3_W-1:0]   w_s3_d;
  logic [S3_W-1:0]   w_s3_q;
  logic [SUM_W-1:0]  w_sum_3;
  logic [PROD_W-1:0] w_p2_3;

  logic [DIFF_W-1:0] w_diff;
  logic [DIFF_W-1:0] w_r4;

  // Stage 1: operand capture, gated by load.
  assign w_s1_d = {a, b, c, d, e};
  assign {w_a1, w_b1, w_c1, w_d1, w_e1} = w_s1_q;

  arith_pipeline_pipe_reg #(.WIDTH(S1_W)) u_stage1 (
    .clk   (clk),
    .clear (clear),
    .i_en  (load),
    .i_d   (w_s1_d),
    .o_q   (w_s1_q)
  );

  // Operands are zero-extended so the products are computed at full 2W width.
  assign w_p1   = {{W{1'b0}}, w_a1} * {{W{1'b0}}, w_b1};
  assign w_p2   = {{W{1'b0}}, w_d1} * {{W{1'b0}}, w_e1};
  assign w_s2_d = {w_p1, w_p2, w_c1};
  assign {w_p1_2, w_p2_2, w_c2} = w_s2_q;

  arith_pipeline_pipe_reg #(.WIDTH(S2_W)) u_stage2 (
    .clk   (clk),
    .clear (clear),
    .i_en  (1'b1),
    .i_d   (w_s2_d),
    .o_q   (w_s2_q)
  );

  assign w_sum  = {1'b0, w_p1_2} + {{(W + 1){1'b0}}, w_c2};
  assign w_s3_d = {w_sum, w_p2_2};
  assign {w_sum_3, w_p2_3} = w_s3_q;

  arith_pipeline_pipe_reg #(.WIDTH(S3_W)) u_stage3 (
    .clk   (clk),
    .clear (clear),
    .i_en  (1'b1),
    .i_d   (w_s3_d),
    .o_q   (w_s3_q)
  );

  // Two's-complement difference; the low W bits are the result modulo 2^W.
  assign w_diff = {1'b0, w_sum_3} - {2'b00, w_p2_3};

  arith_pipeline_pipe_reg #(.WIDTH(DIFF_W)) u_stage4 (
    .clk   (clk),
    .clear (clear),
    .i_en  (1'b1),
    .i_d   (w_diff),
    .o_q   (w_r4)
  );

  assign res = w_r4[W-1:0];

endmodule

// File: tb/tb_arith_pipeline.sv
// Scoreboard bench for arith_pipeline: expected results queued at capture, compared three clocks later.
module tb_arith_pipeline;
  import arith_pipeline_pkg::*;

  localparam int W   = W_DEFAULT;
  localparam int LAT = 3;

  logic clk;
  logic clear;

  arith_pipeline_if #(.W(W)) bus ();

  arith_pipeline #(.W(W)) dut (
    .a     (bus.a),
    .b     (bus.b),
    .c     (bus.c),
    .d     (bus.d),
    .e     (bus.e),
    .clk   (clk),
    .load  (bus.load),
    .clear (clear),
    .res   (bus.res)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_a, m_b, m_c, m_d, m_e;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic logic [W-1:0] ref_res(input logic [W-1:0] ra, rb, rc, rd, re);
    int v;
    logic [31:0] t;
    v = int'(ra) * int'(rb) + int'(rc) - int'(rd) * int'(re);
    t = v;
    return t[W-1:0];
  endfunction

  task automatic sb_reset();
    exp_q.delete();
    m_a = '0; m_b = '0; m_c = '0; m_d = '0; m_e = '0;
    for (int i = 0; i < LAT; i++) exp_q.push_back('0);
  endtask

  // One clock: drive inputs, take the edge, update the capture model, compare the oldest expectation.
  task automatic step(input string tag, input logic ld,
                      input logic [W-1:0] ia, ib, ic, id, ie);
    bus.load = ld; bus.a = ia; bus.b = ib; bus.c = ic; bus.d = id; bus.e = ie;
    @(posedge clk);
    #1;
    if (ld) begin
      m_a = ia; m_b = ib; m_c = ic; m_d = id; m_e = ie;
    end
    exp_q.push_back(ref_res(m_a, m_b, m_c, m_d, m_e));
    check_val(tag, bus.res, exp_q.pop_front());
  endtask

  initial begin
    clear = 1'b1;
    bus.load = 1'b0;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0; bus.e = '0;

    #2  check_val("reset_t2", bus.res, 3'd0);
    #10 check_val("reset_t12", bus.res, 3'd0);
    #10 check_val("reset_t22", bus.res, 3'd0);
    #3  clear = 1'b0;
    sb_reset();

    step("idle_after_release", 1'b0, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5);

    step("seq_1",   1'b1, 3'd1, 3'd0, 3'd3, 3'd1, 3'd2);
    step("seq_5",   1'b1, 3'd7, 3'd1, 3'd0, 3'd2, 3'd1);
    step("seq_0",   1'b1, 3'd2, 3'd2, 3'd2, 3'd6, 3'd1);
    step("neg_wrap", 1'b1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1);
    step("max_ops", 1'b1, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0);
    step("hold_cap", 1'b1, 3'd3, 3'd3, 3'd1, 3'd1, 3'd1);
    for (int i = 0; i < 8; i++) begin
      step("hold_garbage", 1'b0, W'($urandom), W'($urandom), W'($urandom),
           W'($urandom), W'($urandom));
    end
    check_val("hold_value_1", bus.res, 3'd1);

    for (int i = 0; i < 24; i++) begin
      step("random", 1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
           W'($urandom), W'($urandom), W'($urandom));
    end

    step("flight_1", 1'b1, 3'd1, 3'd0, 3'd3, 3'd1, 3'd2);
    step("flight_2", 1'b1, 3'd7, 3'd1, 3'd0, 3'd2, 3'd1);
    step("flight_3", 1'b1, 3'd3, 3'd3, 3'd1, 3'd1, 3'd1);
    bus.load = 1'b0;
    #2 clear = 1'b1;
    #1 check_val("clear_async", bus.res, 3'd0);
    @(posedge clk);
    #1 check_val("clear_held", bus.res, 3'd0);
    #3 clear = 1'b0;
    sb_reset();
    for (int i = 0; i < 6; i++) begin
      step("after_clear", 1'b0, W'($urandom), W'($urandom), W'($urandom),
           W'($urandom), W'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
